// File: rtl/sprite_compositor.sv
// Per-pixel game compositor: sky, ground, player and enemy sprites, pixel collision and game FSM.
// Optional macro DEAD_FLASH_EN: DEAD colour and led blink with an 8-frame half-period.
module sprite_compositor #(
  parameter int unsigned COORD_W  = 16,
  parameter int unsigned N_ENEMY  = 4,
  parameter int unsigned SPR_W    = 100,
  parameter int unsigned SPR_H    = 60,
  parameter int unsigned INSET    = 10,
  parameter int unsigned GROUND_Y = 460,
  parameter int unsigned H_ACT_LO = 144,
  parameter int unsigned H_ACT_HI = 783,
  parameter int unsigned V_ACT_LO = 35,
  parameter int unsigned V_ACT_HI = 514
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [COORD_W-1:0]           x,
  input  logic [COORD_W-1:0]           y,
  input  logic                         frame_start,
  input  logic                         start,
  input  logic [COORD_W-1:0]           x_player,
  input  logic [COORD_W-1:0]           y_player,
  input  logic [N_ENEMY*COORD_W-1:0]   x_enemy,
  input  logic [N_ENEMY*COORD_W-1:0]   y_enemy,
  input  logic [N_ENEMY-1:0]           enemy_en,
  output logic [3:0]                   Red,
  output logic [3:0]                   Green,
  output logic [3:0]                   Blue,
  output logic                         led,
  output logic [1:0]                   state_o,
  output logic [15:0]                  score
);

  localparam int unsigned CW1 = COORD_W + 1;

  localparam logic [1:0] StInitial = 2'b00;
  localparam logic [1:0] StPlaying = 2'b01;
  localparam logic [1:0] StDead    = 2'b10;

  localparam logic [11:0] ColBlack  = 12'h000;
  localparam logic [11:0] ColRed    = 12'hF00;
  localparam logic [11:0] ColGreen  = 12'h0F0;
  localparam logic [11:0] ColWhite  = 12'hFFF;
  localparam logic [11:0] ColYellow = 12'hFF0;
  localparam logic [11:0] ColSky    = 12'h8EE;

  // Open-interval box test; bounds carry one extra bit so boxes near the max clip, not wrap.
  function automatic logic in_box(input logic [CW1-1:0] px, input logic [CW1-1:0] py,
                                  input logic [CW1-1:0] lx, input logic [CW1-1:0] ly,
                                  input logic [CW1-1:0] hx, input logic [CW1-1:0] hy);
    return (px > lx) && (px < hx) && (py > ly) && (py < hy);
  endfunction

  // Stage 1 combinational hits
  logic [CW1-1:0] xe, ye, pxl, pyl;
  logic           vis_d, pl_d, pin_d, en_d, gnd_d;

  always_comb begin
    xe    = {1'b0, x};
    ye    = {1'b0, y};
    pxl   = {1'b0, x_player};
    pyl   = {1'b0, y_player};
    vis_d = (x > COORD_W'(H_ACT_LO)) && (x <= COORD_W'(H_ACT_HI)) &&
            (y > COORD_W'(V_ACT_LO)) && (y <= COORD_W'(V_ACT_HI));
    gnd_d = y > COORD_W'(GROUND_Y);
    pl_d  = in_box(xe, ye, pxl, pyl, pxl + CW1'(SPR_W), pyl + CW1'(SPR_H));
    pin_d = in_box(xe, ye, pxl + CW1'(INSET), pyl + CW1'(INSET),
                   pxl + CW1'(SPR_W - INSET), pyl + CW1'(SPR_H - INSET));
    en_d  = 1'b0;
    for (int i = 0; i < N_ENEMY; i++) begin
      en_d = en_d | (enemy_en[i] &&
             in_box(xe, ye,
                    {1'b0, x_enemy[i*COORD_W +: COORD_W]},
                    {1'b0, y_enemy[i*COORD_W +: COORD_W]},
                    {1'b0, x_enemy[i*COORD_W +: COORD_W]} + CW1'(SPR_W),
                    {1'b0, y_enemy[i*COORD_W +: COORD_W]} + CW1'(SPR_H)));
    end
  end

  logic vis_q, pl_q, pin_q, en_q, gnd_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vis_q <= 1'b0;
      pl_q  <= 1'b0;
      pin_q <= 1'b0;
      en_q  <= 1'b0;
      gnd_q <= 1'b0;
    end else begin
      vis_q <= vis_d;
      pl_q  <= pl_d;
      pin_q <= pin_d;
      en_q  <= en_d;
      gnd_q <= gnd_d;
    end
  end

  // Game state
  logic [1:0]  state_q, state_d;
  logic [15:0] score_q, score_d;
  logic        collide_q, collide_d;
  logic        start_pend_q, start_pend_d;
  logic        led_q, led_d;
  logic        hit;
  logic        go;
  logic        dead_red;

`ifdef DEAD_FLASH_EN
  logic [3:0] flash_cnt_q, flash_cnt_d;
`endif

  always_comb begin
    hit          = vis_q && pl_q && en_q && (state_q == StPlaying);
    go           = start_pend_q || start;
    state_d      = state_q;
    score_d      = score_q;
    collide_d    = collide_q || hit;
    start_pend_d = start_pend_q || (start && (state_q != StPlaying));
    if (frame_start) begin
      case (state_q)
        StInitial, StDead: begin
          if (go) begin
            state_d      = StPlaying;
            score_d      = 16'd0;
            collide_d    = 1'b0;
            start_pend_d = 1'b0;
          end
        end
        StPlaying: begin
          if (collide_q) begin
            state_d = StDead;
          end else if (score_q != 16'hFFFF) begin
            score_d = score_q + 16'd1;
          end
        end
        default: state_d = StInitial;
      endcase
    end
  end

`ifdef DEAD_FLASH_EN
  always_comb begin
    flash_cnt_d = flash_cnt_q;
    if ((state_d == StDead) && (state_q != StDead)) begin
      flash_cnt_d = 4'd0;
    end else if ((state_q == StDead) && frame_start) begin
      flash_cnt_d = flash_cnt_q + 4'd1;
    end
    led_d    = (state_d == StDead) && !flash_cnt_d[3];
    dead_red = !flash_cnt_q[3];
  end
`else
  always_comb begin
    led_d    = state_d == StDead;
    dead_red = 1'b1;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StInitial;
      score_q      <= 16'd0;
      collide_q    <= 1'b0;
      start_pend_q <= 1'b0;
      led_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      collide_q    <= collide_d;
      start_pend_q <= start_pend_d;
      led_q        <= led_d;
    end
  end

`ifdef DEAD_FLASH_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flash_cnt_q <= 4'd0;
    end else begin
      flash_cnt_q <= flash_cnt_d;
    end
  end
`endif

  // Stage 2 colour select
  logic [11:0] rgb_q, rgb_d;

  always_comb begin
    if (!vis_q) begin
      rgb_d = ColBlack;
    end else if (state_q == StDead) begin
      rgb_d = dead_red ? ColRed : ColBlack;
    end else if (gnd_q) begin
      rgb_d = ColGreen;
    end else if ((state_q == StPlaying) && pin_q) begin
      rgb_d = ColWhite;
    end else if ((state_q == StPlaying) && pl_q) begin
      rgb_d = ColYellow;
    end else if ((state_q == StPlaying) && en_q) begin
      rgb_d = ColBlack;
    end else begin
      rgb_d = ColSky;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q <= ColBlack;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign Red     = rgb_q[11:8];
  assign Green   = rgb_q[7:4];
  assign Blue    = rgb_q[3:0];
  assign led     = led_q;
  assign state_o = state_q;
  assign score   = score_q;

endmodule
